// File: rtl/block_pe_pkg.sv
// ----------------------------------------------------------------------------
// block_pe_pkg : op codes, width helpers and config field offsets for block_pe_gen
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package block_pe_pkg;

  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MIN  = 4'd10;
  localparam logic [3:0] OP_MAX  = 4'd11;
  localparam logic [3:0] OP_MAC  = 4'd12;
  localparam logic [3:0] OP_ACC  = 4'd13;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int cfg_width(input int w, input int n, input int d, input int a);
    return 2 * clog2(n + 2) + 4 + clog2(d + 1) + a + w;
  endfunction

  // Field offsets, LSB first: sel_a, sel_b, op, dly, acc_len, const
  localparam int OFF_SEL_A = 0;

  function automatic int off_sel_b(input int n);
    return clog2(n + 2);
  endfunction

  function automatic int off_op(input int n);
    return 2 * clog2(n + 2);
  endfunction

  function automatic int off_dly(input int n);
    return off_op(n) + 4;
  endfunction

  function automatic int off_acc(input int n, input int d);
    return off_dly(n) + clog2(d + 1);
  endfunction

  function automatic int off_const(input int n, input int d, input int a);
    return off_acc(n, d) + a;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pe_delay_line.sv
// ----------------------------------------------------------------------------
// pe_delay_line : tapped {data, valid} shift register with clamped tap select
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pe_delay_line
  import block_pe_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MAX_DLY = 4,
  parameter int DLY_W   = clog2(MAX_DLY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  input  logic [DLY_W-1:0] i_dly,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_data [MAX_DLY];
  logic             r_vld  [MAX_DLY];
  logic [DLY_W-1:0] w_tap;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < MAX_DLY; k++) begin
        r_data[k] <= '0;
        r_vld[k]  <= 1'b0;
      end
    end else begin
      r_data[0] <= i_data;
      r_vld[0]  <= i_valid;
      for (int k = 1; k < MAX_DLY; k++) begin
        r_data[k] <= r_data[k-1];
        r_vld[k]  <= r_vld[k-1];
      end
    end
  end

  assign w_tap = (i_dly > DLY_W'(MAX_DLY)) ? DLY_W'(MAX_DLY) : i_dly;

  // Tap 0 is the undelayed stage-0 input; tap k is shift stage k
  always_comb begin
    o_data  = i_data;
    o_valid = i_valid;
    for (int k = 1; k <= MAX_DLY; k++) begin
      if (w_tap == DLY_W'(k)) begin
        o_data  = r_data[k-1];
        o_valid = r_vld[k-1];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/block_pe_gen.sv
// ----------------------------------------------------------------------------
// block_pe_gen : CGRA PE with operand crossbar, accumulating ALU, serial config
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module block_pe_gen
  import block_pe_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_IN  = 4,
  parameter int MAX_DLY = 4,
  parameter int ACC_W   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    config_en,
  input  logic                    config_in,
  output logic                    config_out,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic [WIDTH-1:0]        out0,
  output logic                    out_valid
);

  localparam int SEL_W     = clog2(NUM_IN + 2);
  localparam int DLY_W     = clog2(MAX_DLY + 1);
  localparam int CFG_W     = cfg_width(WIDTH, NUM_IN, MAX_DLY, ACC_W);
  localparam int SH_W      = clog2(WIDTH);
  localparam int OFF_SEL_B = off_sel_b(NUM_IN);
  localparam int OFF_OP    = off_op(NUM_IN);
  localparam int OFF_DLY   = off_dly(NUM_IN);
  localparam int OFF_ACC   = off_acc(NUM_IN, MAX_DLY);
  localparam int OFF_CONST = off_const(NUM_IN, MAX_DLY, ACC_W);

  logic [CFG_W-1:0] r_cfg;
  logic [WIDTH-1:0] r_alu_q;
  logic             r_v0;
  logic [WIDTH-1:0] r_acc;
  logic [ACC_W-1:0] r_cnt;

  logic [SEL_W-1:0] w_sel_a;
  logic [SEL_W-1:0] w_sel_b;
  logic [3:0]       w_op;
  logic [DLY_W-1:0] w_dly;
  logic [ACC_W-1:0] w_acc_len;
  logic [WIDTH-1:0] w_const;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_prod;
  logic [SH_W-1:0]  w_shamt;
  logic [WIDTH-1:0] w_result;
  logic             w_eff_valid;
  logic             w_is_acc;
  logic             w_acc_wrap;

  assign w_sel_a   = r_cfg[OFF_SEL_A +: SEL_W];
  assign w_sel_b   = r_cfg[OFF_SEL_B +: SEL_W];
  assign w_op      = r_cfg[OFF_OP    +: 4];
  assign w_dly     = r_cfg[OFF_DLY   +: DLY_W];
  assign w_acc_len = r_cfg[OFF_ACC   +: ACC_W];
  assign w_const   = r_cfg[OFF_CONST +: WIDTH];

  assign config_out  = r_cfg[0];
  assign w_eff_valid = in_valid & ~config_en;

  // Operand crossbar: data inputs, feedback, constant; unused codes read as zero
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_sel_a == SEL_W'(i)) w_a = in_data[i*WIDTH +: WIDTH];
      if (w_sel_b == SEL_W'(i)) w_b = in_data[i*WIDTH +: WIDTH];
    end
    if (w_sel_a == SEL_W'(NUM_IN))     w_a = r_alu_q;
    if (w_sel_b == SEL_W'(NUM_IN))     w_b = r_alu_q;
    if (w_sel_a == SEL_W'(NUM_IN + 1)) w_a = w_const;
    if (w_sel_b == SEL_W'(NUM_IN + 1)) w_b = w_const;
  end

  assign w_prod  = w_a * w_b;
  assign w_shamt = w_b[SH_W-1:0];

  always_comb begin
    w_result = '0;
    case (w_op)
      OP_PASS: w_result = w_a;
      OP_ADD:  w_result = w_a + w_b;
      OP_SUB:  w_result = w_a - w_b;
      OP_MUL:  w_result = w_prod;
      OP_AND:  w_result = w_a & w_b;
      OP_OR:   w_result = w_a | w_b;
      OP_XOR:  w_result = w_a ^ w_b;
      OP_SHL:  w_result = w_a << w_shamt;
      OP_SHR:  w_result = w_a >> w_shamt;
      OP_SRA:  w_result = $signed(w_a) >>> w_shamt;
      OP_MIN:  w_result = ($signed(w_a) < $signed(w_b)) ? w_a : w_b;
      OP_MAX:  w_result = ($signed(w_a) > $signed(w_b)) ? w_a : w_b;
      OP_MAC:  w_result = r_acc + w_prod;
      OP_ACC:  w_result = r_acc + w_a;
      default: w_result = '0;
    endcase
  end

  assign w_is_acc   = (w_op == OP_MAC) || (w_op == OP_ACC);
  assign w_acc_wrap = (w_acc_len != '0) && (r_cnt == w_acc_len - 1'b1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cfg   <= '0;
      r_alu_q <= '0;
      r_v0    <= 1'b0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      if (config_en) r_cfg <= {config_in, r_cfg[CFG_W-1:1]};
      r_v0 <= w_eff_valid;
      if (w_eff_valid) r_alu_q <= w_result;
      if (config_en || !w_is_acc) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_eff_valid) begin
        // Final sample of a window still reaches alu_q; the next one starts at zero
        if (w_acc_wrap) begin
          r_acc <= '0;
          r_cnt <= '0;
        end else begin
          r_acc <= w_result;
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  pe_delay_line #(
    .WIDTH   (WIDTH),
    .MAX_DLY (MAX_DLY),
    .DLY_W   (DLY_W)
  ) u_dly (
    .clk     (clk),
    .rst     (reset),
    .i_data  (r_alu_q),
    .i_valid (r_v0),
    .i_dly   (w_dly),
    .o_data  (out0),
    .o_valid (out_valid)
  );

endmodule

`default_nettype wire

// File: doc/block_pe_gen.md
Name: block_pe_gen

Overview:
- Parametrised next-generation CGRA processing element.
- Operand crossbar with NUM_IN inputs, a feedback path and a constant. Feeds a registered ALU with accumulate/MAC modes and a configurable-depth output delay line for path balancing.
- Configuration is a serial shift chain on the datapath clock, daisy-chained PE to PE through config_in/config_out.
- Adds valid tagging, which earlier PE blocks lack.

Parameters:
- WIDTH, 32, datapath width in bits.
- NUM_IN, 4, number of data inputs (at least 1).
- MAX_DLY, 4, maximum extra output delay in cycles.
- ACC_W, 8, width of the accumulate-length counter.

Ports:
- clk  in  1  sole clock, datapath and config chain.
- reset  in  1  synchronous, active-high.
- config_en  in  1  shift config chain this cycle.
- config_in  in  1  serial config data in.
- config_out  out  1  serial config data out, equal to cfg[0].
- in_data  in  NUM_IN*WIDTH  flattened inputs; input i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  1  operands valid this cycle.
- out0  out  WIDTH  result.
- out_valid  out  1  out0 valid.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- Derived widths:
  - SEL_W = clog2(NUM_IN+2).
  - DLY_W = clog2(MAX_DLY+1).
  - CFG_W = 2*SEL_W + 4 + DLY_W + ACC_W + WIDTH.
- Config fields, LSB first: sel_a, sel_b, op[3:0], dly, acc_len, const.
- Config shift: when config_en=1, cfg <= {config_in, cfg[CFG_W-1:1]}. The first bit shifted in lands at cfg[0] after CFG_W shifts.
- Reset: at reset=1, all of the following clear to 0, and reset has priority over config_en:
  - cfg, acc, cnt
  - alu_q and its valid bit
  - all delay-stage data and valid bits
  - out0 and out_valid
- Operand sources for sel_a/sel_b:
  - 0..NUM_IN-1: in_data slice.
  - NUM_IN: alu_q (feedback).
  - NUM_IN+1: const.
  - Larger codes: 0.
- Stage 0 registers alu_q and v0 every cycle, with eff_valid = in_valid & ~config_en.
- ALU ops on a and b (shift amount = b[clog2(WIDTH)-1:0]):
  - 0 pass a; 1 a+b; 2 a-b; 3 a*b (low WIDTH bits).
  - 4 and; 5 or; 6 xor.
  - 7 shl; 8 logical shr; 9 arithmetic shr.
  - 10 signed min; 11 signed max.
  - 12 MAC: acc + a*b.
  - 13 ACC: acc + a.
  - 14 and 15 produce 0.
  - Wrap-around modulo 2^WIDTH, no saturation.
- alu_q update: updates only when eff_valid=1; otherwise holds and v0 <= 0.
- Accumulate modes (ops 12/13), on an eff_valid cycle:
  - acc <= result and alu_q <= result.
  - cnt increments.
  - If acc_len != 0 and cnt == acc_len-1: acc <= 0 and cnt <= 0 instead, so the next sample restarts from zero. alu_q still takes the final sum.
  - acc_len = 0 means never restart; the counter wraps silently.
- Non-accumulate ops: acc and cnt held at 0.
- Any cycle with config_en=1 clears acc and cnt.
- Delay line:
  - MAX_DLY stages shift {data, valid} from stage 0 every cycle, unconditionally.
  - out0/out_valid = tap dly; dly=0 taps stage 0 directly.
  - dly > MAX_DLY clamps to MAX_DLY.
  - Latency from in_valid to out_valid = 1 + dly cycles.
- Changing config mid-stream: bubbles (valid=0) are inserted while config_en=1. Data already in the delay line drains with its valid bits intact.

Decomposition:
- Package block_pe_pkg holds:
  - the op code localparams (OP_PASS … OP_ACC);
  - functions clog2 and cfg_width(WIDTH, NUM_IN, MAX_DLY, ACC_W);
  - the field offset constants.
- Sub-module pe_delay_line (parameters WIDTH, MAX_DLY) holds:
  - the tapped {data, valid} shift register;
  - the clamp logic.
- The top level keeps the config chain, crossbar, ALU and accumulator.

Test Plan:
- Reset: hold reset 2 cycles while driving config_en=1 -> config_out=0, out0=0, out_valid=0, and cfg stays 0.
- ADD with dly=0: configure sel_a=0, sel_b=1, op=1; in0=5, in1=7, in_valid=1 -> next cycle out0=12, out_valid=1. Repeat with in0=0xFFFFFFFF, in1=1 -> out0=0.
- Delay: same config, dly=3, single valid pulse in0=2, in1=3 -> out0=5 with out_valid=1 exactly 4 cycles later, valid=0 at every other cycle. dly=7 with MAX_DLY=4 -> latency 5.
- MAC with acc_len=3: inputs a=1..6, b=2, all valid -> out0 = 2, 6, 12, then 8, 18, 30.
- Feedback/const: sel_a=NUM_IN, sel_b=NUM_IN+1, const=1, op=1, in_valid held 1 -> out0 counts 1, 2, 3, …; with in_valid=0 for 2 cycles, the count holds and out_valid=0.
- Config chain: shift a known CFG_W pattern, then CFG_W more zeros -> config_out reproduces the pattern bit-for-bit. A config_en pulse mid-MAC clears acc, so the next valid sample restarts from 0.
